// File: rtl/ins_encoder.sv
// Instruction encoder/loader: packs one symbolic instruction per handshake into
// the decoder's 32-bit format and writes it sequentially into instruction memory.
//
// state   | meaning
// S_IDLE  | ready for a request unless memory is full
// S_ENC   | latched request is encoded and range-checked
// S_WRITE | encoded word presented on the write port for one cycle
module ins_encoder #(
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [4:0]    req_op,
  input  logic [4:0]    req_rd,
  input  logic [4:0]    req_ra,
  input  logic [4:0]    req_rb,
  input  logic [1:0]    req_sv,
  input  logic [31:0]   req_imm,
  input  logic          rewind,
  output logic          im_wen,
  output logic [AW-1:0] im_addr,
  output logic [31:0]   im_wdata,
  output logic          err,
  output logic [1:0]    err_code,
  output logic          full,
  output logic [AW:0]   count
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ENC   = 2'd1,
    S_WRITE = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_next;

  logic [4:0]    r_op;
  logic [4:0]    r_rd;
  logic [4:0]    r_ra;
  logic [4:0]    r_rb;
  logic [1:0]    r_sv;
  logic [31:0]   r_imm;

  logic          r_wen;
  logic [31:0]   r_wdata;
  logic          r_err;
  logic [1:0]    r_code;
  logic          r_full;
  logic [AW-1:0] r_wptr;
  logic [AW:0]   r_count;

  logic          w_accept;
  logic [5:0]    w_opc;
  logic [4:0]    w_sub;
  logic [14:0]   w_lo;
  logic [31:0]   w_word;
  logic          w_illegal;
  logic          w_misalign;
  logic          w_range;
  logic [1:0]    w_code;
  logic          w_ok;

  assign req_ready = (r_state == S_IDLE) && !r_full;
  assign w_accept  = req_valid && req_ready;

  always_comb begin
    w_sub = 5'b00000;
    case (r_op[2:0])
      3'd0:    w_sub = 5'b00000;
      3'd1:    w_sub = 5'b00001;
      3'd2:    w_sub = 5'b00010;
      3'd3:    w_sub = 5'b00100;
      3'd4:    w_sub = 5'b00011;
      3'd5:    w_sub = 5'b01001;
      3'd6:    w_sub = 5'b01000;
      default: w_sub = 5'b01011;
    endcase
  end

  // Range checks test that the immediate fits the field as a signed/unsigned value.
  always_comb begin
    w_opc      = 6'b100000;
    w_lo       = '0;
    w_illegal  = 1'b0;
    w_misalign = 1'b0;
    w_range    = 1'b0;
    case (r_op)
      5'd0, 5'd1, 5'd2, 5'd3, 5'd4: begin
        w_lo = {r_rb, 5'b00000, w_sub};
      end
      5'd5, 5'd6, 5'd7: begin
        w_lo    = {r_imm[4:0], 5'b00000, w_sub};
        w_range = |r_imm[31:5];
      end
      5'd8: begin
        w_opc   = 6'b101000;
        w_lo    = r_imm[14:0];
        w_range = !((r_imm[31:14] == '0) || (r_imm[31:14] == '1));
      end
      5'd9: begin
        w_opc   = 6'b101100;
        w_lo    = r_imm[14:0];
        w_range = |r_imm[31:15];
      end
      5'd10: begin
        w_opc   = 6'b101011;
        w_lo    = r_imm[14:0];
        w_range = |r_imm[31:15];
      end
      5'd11, 5'd12: begin
        w_opc      = (r_op == 5'd11) ? 6'b000010 : 6'b001010;
        w_lo       = r_imm[16:2];
        w_misalign = |r_imm[1:0];
        w_range    = |r_imm[31:17];
      end
      5'd13: begin
        w_opc   = 6'b100010;
        w_range = !((r_imm[31:19] == '0) || (r_imm[31:19] == '1));
      end
      5'd14: begin
        w_opc = 6'b011100;
        w_lo  = {r_rb, r_sv, 8'h02};
      end
      5'd15: begin
        w_opc = 6'b011100;
        w_lo  = {r_rb, r_sv, 8'h0A};
      end
      5'd16, 5'd17: begin
        w_opc      = 6'b100110;
        w_lo       = {r_op[0], r_imm[14:1]};
        w_misalign = r_imm[0];
        w_range    = !((r_imm[31:14] == '0) || (r_imm[31:14] == '1));
      end
      5'd18: begin
        w_opc      = 6'b100100;
        w_misalign = r_imm[0];
        w_range    = !((r_imm[31:24] == '0) || (r_imm[31:24] == '1));
      end
      default: begin
        w_illegal = 1'b1;
      end
    endcase
  end

  // MOVI and J immediates overwrite the register fields of the common layout.
  always_comb begin
    w_word = {1'b0, w_opc, r_rd, r_ra, w_lo};
    if (r_op == 5'd13) begin
      w_word[19:0] = r_imm[19:0];
    end
    if (r_op == 5'd18) begin
      w_word[24:0] = {1'b0, r_imm[24:1]};
    end
  end

  always_comb begin
    if (w_illegal) begin
      w_code = 2'd1;
    end else if (w_misalign) begin
      w_code = 2'd3;
    end else if (w_range) begin
      w_code = 2'd2;
    end else begin
      w_code = 2'd0;
    end
  end

  assign w_ok = (w_code == 2'd0);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = S_ENC;
      S_ENC:   w_next = w_ok ? S_WRITE : S_IDLE;
      S_WRITE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_op    <= '0;
      r_rd    <= '0;
      r_ra    <= '0;
      r_rb    <= '0;
      r_sv    <= '0;
      r_imm   <= '0;
      r_wen   <= 1'b0;
      r_wdata <= '0;
      r_err   <= 1'b0;
      r_code  <= '0;
      r_full  <= 1'b0;
      r_wptr  <= '0;
      r_count <= '0;
    end else begin
      r_state <= w_next;
      r_wen   <= (r_state == S_ENC) && w_ok;
      r_err   <= (r_state == S_ENC) && !w_ok;
      if ((r_state == S_ENC) && !w_ok) begin
        r_code <= w_code;
      end
      if ((r_state == S_ENC) && w_ok) begin
        r_wdata <= w_word;
      end
      if (w_accept) begin
        r_op  <= req_op;
        r_rd  <= req_rd;
        r_ra  <= req_ra;
        r_rb  <= req_rb;
        r_sv  <= req_sv;
        r_imm <= req_imm;
      end
      // A rewind during the write lets it land at the old address, then restarts at 0.
      if (rewind) begin
        r_wptr  <= '0;
        r_count <= '0;
        r_full  <= 1'b0;
      end else if (r_state == S_WRITE) begin
        r_wptr  <= r_wptr + 1'b1;
        r_count <= r_count + 1'b1;
        r_full  <= &r_wptr;
      end
    end
  end

  assign im_wen   = r_wen;
  assign im_addr  = r_wptr;
  assign im_wdata = r_wdata;
  assign err      = r_err;
  assign err_code = r_code;
  assign full     = r_full;
  assign count    = r_count;

endmodule

// File: tb/tb_ins_encoder.sv
// Bench for ins_encoder (AW=2): directed program/boundary cases plus random
// traffic checked every cycle against a transaction-level reference model.
module tb_ins_encoder;
  localparam int AW = 2;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          rewind = 1'b0;
  logic [4:0]    req_op = '0;
  logic [4:0]    req_rd = '0;
  logic [4:0]    req_ra = '0;
  logic [4:0]    req_rb = '0;
  logic [1:0]    req_sv = '0;
  logic [31:0]   req_imm = '0;
  logic          req_ready;
  logic          im_wen;
  logic [AW-1:0] im_addr;
  logic [31:0]   im_wdata;
  logic          err;
  logic [1:0]    err_code;
  logic          full;
  logic [AW:0]   count;

  always #5 clk = ~clk;

  ins_encoder #(.AW(AW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_rd(req_rd), .req_ra(req_ra), .req_rb(req_rb),
    .req_sv(req_sv), .req_imm(req_imm), .rewind(rewind), .im_wen(im_wen),
    .im_addr(im_addr), .im_wdata(im_wdata), .err(err), .err_code(err_code),
    .full(full), .count(count)
  );

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_on = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Legal immediate window and alignment per operation, straight from the op table.
  function automatic void rng(input int op, output bit has, output longint lo,
                              output longint hi, output int al);
    has = 1'b1; lo = 0; hi = 0; al = 1;
    case (op)
      5, 6, 7:  begin lo = 0;        hi = 31;       end
      8:        begin lo = -16384;   hi = 16383;    end
      9, 10:    begin lo = 0;        hi = 32767;    end
      11, 12:   begin lo = 0;        hi = 131068;   al = 4; end
      13:       begin lo = -524288;  hi = 524287;   end
      16, 17:   begin lo = -16384;   hi = 16382;    al = 2; end
      18:       begin lo = -(64'sd1 <<< 24); hi = (64'sd1 <<< 24) - 2; al = 2; end
      default:  has = 1'b0;
    endcase
  endfunction

  function automatic int sub_of(input int op);
    case (op)
      0: return 0;  1: return 1;  2: return 2;  3: return 4;
      4: return 3;  5: return 9;  6: return 8;  default: return 11;
    endcase
  endfunction

  function automatic void ref_enc(input int op, input int rd, input int ra, input int rb,
                                  input int sv, input longint imm,
                                  output logic [31:0] w, output int code);
    longint opc, body, wl, lo, hi;
    bit has;
    int al;
    rng(op, has, lo, hi, al);
    opc = 0; body = 0;
    case (op)
      0, 1, 2, 3, 4: begin opc = 32; body = rb * 1024 + sub_of(op); end
      5, 6, 7:  begin opc = 32; body = (imm & 64'h1F) * 1024 + sub_of(op); end
      8:        begin opc = 40; body = imm & 64'h7FFF; end
      9:        begin opc = 44; body = imm & 64'h7FFF; end
      10:       begin opc = 43; body = imm & 64'h7FFF; end
      11:       begin opc = 2;  body = (imm >>> 2) & 64'h7FFF; end
      12:       begin opc = 10; body = (imm >>> 2) & 64'h7FFF; end
      14:       begin opc = 28; body = rb * 1024 + sv * 256 + 2; end
      15:       begin opc = 28; body = rb * 1024 + sv * 256 + 10; end
      16:       begin opc = 38; body = (imm >>> 1) & 64'h3FFF; end
      17:       begin opc = 38; body = 16384 + ((imm >>> 1) & 64'h3FFF); end
      13:       opc = 34;
      18:       opc = 36;
      default:  opc = 0;
    endcase
    if (op == 13)      wl = (opc << 25) + (longint'(rd) << 20) + (imm & 64'hFFFFF);
    else if (op == 18) wl = (opc << 25) + ((imm >>> 1) & 64'hFFFFFF);
    else               wl = (opc << 25) + (longint'(rd) << 20) + (longint'(ra) << 15) + body;
    w = wl[31:0];
    if (op > 18)                            code = 1;
    else if (al > 1 && (imm % al) != 0)     code = 3;
    else if (has && (imm < lo || imm > hi)) code = 2;
    else                                    code = 0;
  endfunction

  function automatic logic [31:0] mw(input int op, input int rd, input int ra, input int rb,
                                     input int sv, input longint imm);
    logic [31:0] w;
    int c;
    ref_enc(op, rd, ra, rb, sv, imm, w, c);
    return w;
  endfunction

  function automatic int mc(input int op, input longint imm);
    logic [31:0] w;
    int c;
    ref_enc(op, 0, 0, 0, 0, imm, w, c);
    return c;
  endfunction

  // Transaction timeline model: a request accepted at the end of cycle A
  // resolves in cycle A+2 (write or error) and the block is idle again after it.
  int          cyc = 0;
  int          m_acc = -100;
  bit          m_ok = 1'b0;
  logic [31:0] m_word = '0;
  int          m_rc = 0;
  int          m_wptr = 0;
  int          m_count = 0;
  bit          m_full = 1'b0;
  int          m_code = 0;
  bit          m_fb;
  bit          m_idle;
  bit          e_wen = 1'b0;
  bit          e_err = 1'b0;
  bit          e_ready = 1'b1;
  logic [31:0] e_wdata = '0;
  int          e_addr = 0;

  initial forever begin
    @(posedge clk);
    if (rst) begin
      m_acc = -100; m_ok = 1'b0; m_wptr = 0; m_count = 0; m_full = 1'b0; m_code = 0;
      e_wen = 1'b0; e_err = 1'b0; e_ready = 1'b1; e_wdata = '0; e_addr = 0;
    end else begin
      m_fb = m_full;
      m_idle = (cyc >= m_acc + (m_ok ? 3 : 2));
      if (rewind) begin
        m_wptr = 0; m_count = 0; m_full = 1'b0;
      end else if (m_ok && cyc == m_acc + 2) begin
        m_full = (m_wptr == DEPTH - 1);
        m_wptr = (m_wptr + 1) % DEPTH;
        m_count++;
      end
      if (m_idle && !m_fb && req_valid) begin
        m_acc = cyc;
        ref_enc(int'(req_op), int'(req_rd), int'(req_ra), int'(req_rb), int'(req_sv),
                longint'($signed(req_imm)), m_word, m_rc);
        m_ok = (m_rc == 0);
      end
      e_wen = m_ok && (cyc + 1 == m_acc + 2);
      e_err = !m_ok && (cyc + 1 == m_acc + 2);
      if (e_wen) e_wdata = m_word;
      if (e_err) m_code = m_rc;
      e_addr = m_wptr;
      e_ready = (cyc + 1 >= m_acc + (m_ok ? 3 : 2)) && !m_full;
    end
    cyc++;
  end

  initial forever begin
    @(negedge clk);
    if (chk_on) begin
      chk("req_ready", req_ready, e_ready);
      chk("im_wen", im_wen, e_wen);
      chk("im_addr", im_addr, e_addr);
      if (e_wen) chk("im_wdata", im_wdata, e_wdata);
      chk("err", err, e_err);
      chk("err_code", err_code, m_code);
      chk("full", full, m_full);
      chk("count", count, m_count);
    end
  end

  task automatic xact(input int op, input int rd, input int ra, input int rb, input int sv,
                      input longint imm, input bit rw, output bit c_wen, output bit c_err,
                      output logic [AW-1:0] c_addr, output logic [31:0] c_data,
                      output logic [1:0] c_code);
    bit acc;
    acc = 1'b0;
    c_wen = 1'b0; c_err = 1'b0; c_addr = '0; c_data = '0; c_code = '0;
    @(posedge clk); #1;
    req_op = 5'(op); req_rd = 5'(rd); req_ra = 5'(ra); req_rb = 5'(rb);
    req_sv = 2'(sv); req_imm = imm[31:0]; req_valid = 1'b1;
    for (int i = 0; i < 12 && !acc; i++) begin
      @(negedge clk);
      acc = req_ready;
    end
    if (!acc) begin
      chk("accept timeout", 64'd0, 64'd1);
      req_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    if (rw) begin
      @(posedge clk); #1;
      rewind = 1'b1;
    end
    @(negedge clk);
    c_wen = im_wen; c_err = err; c_addr = im_addr; c_data = im_wdata; c_code = err_code;
    if (rw) begin
      @(posedge clk); #1;
      rewind = 1'b0;
    end
  endtask

  task automatic do_word(input string nm, input int op, input int rd, input int ra,
                         input int rb, input int sv, input longint imm, input bit rw,
                         input int ea, input logic [31:0] ew);
    bit w, e;
    logic [AW-1:0] a;
    logic [31:0] d;
    logic [1:0] c;
    xact(op, rd, ra, rb, sv, imm, rw, w, e, a, d, c);
    chk({nm, " wen"}, w, 1);
    chk({nm, " addr"}, a, ea);
    chk({nm, " data"}, d, ew);
  endtask

  task automatic do_err(input string nm, input int op, input longint imm, input int ec);
    bit w, e;
    logic [AW-1:0] a;
    logic [31:0] d;
    logic [1:0] c;
    xact(op, 1, 2, 3, 0, imm, 1'b0, w, e, a, d, c);
    chk({nm, " wen"}, w, 0);
    chk({nm, " err"}, e, 1);
    chk({nm, " code"}, c, ec);
  endtask

  task automatic pulse_rewind();
    @(posedge clk); #1;
    rewind = 1'b1;
    @(posedge clk); #1;
    rewind = 1'b0;
  endtask

  function automatic longint pick_imm(input int op);
    bit has;
    longint lo, hi;
    int al;
    rng(op, has, lo, hi, al);
    case ($urandom_range(0, 5))
      0:       return longint'($urandom_range(0, 48)) - 8;
      1:       return longint'($signed($urandom()));
      2:       return lo;
      3:       return hi;
      4:       return lo - longint'($urandom_range(1, 4));
      default: return hi + longint'($urandom_range(1, 4));
    endcase
  endfunction

  initial begin
    chk("model ADD", mw(0, 3, 2, 4, 0, 0), 32'h40311000);
    chk("model ADDI", mw(8, 5, 0, 0, 0, -1), 32'h50507FFF);
    chk("model BNE", mw(17, 1, 2, 0, 0, -4), 32'h4C117FFE);
    chk("model J", mw(18, 0, 0, 0, 0, 8), 32'h48000004);
    chk("model MOVI", mw(13, 7, 0, 0, 0, -524288), 32'h44780000);
    chk("model LW", mw(14, 1, 2, 3, 2, 0), 32'h38110E02);
    chk("model BEQ odd", mc(16, 3), 3);
    chk("model ORI range", mc(9, 32768), 2);

    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_on = 1'b1;
    rst = 1'b0;
    @(negedge clk);
    chk("reset count", count, 0);
    chk("reset ready", req_ready, 1);
    chk("reset wen", im_wen, 0);
    chk("reset err_code", err_code, 0);

    do_word("ADD", 0, 3, 2, 4, 0, 0, 1'b0, 0, 32'h40311000);
    @(negedge clk);
    chk("count after ADD", count, 1);
    do_word("ADDI", 8, 5, 0, 0, 0, -1, 1'b0, 1, 32'h50507FFF);
    do_word("LWI", 11, 4, 2, 0, 0, 8, 1'b0, 2, 32'h04410002);
    do_err("BEQ odd", 16, 3, 3);
    @(negedge clk);
    chk("count after err", count, 3);

    pulse_rewind();
    do_word("BNE", 17, 1, 2, 0, 0, -4, 1'b0, 0, 32'h4C117FFE);
    do_word("J", 18, 0, 0, 0, 0, 8, 1'b0, 1, 32'h48000004);
    do_err("illegal op", 25, 0, 1);
    do_err("ORI range", 9, 32768, 2);
    do_err("SLLI range", 6, 32, 2);
    do_word("MOVI", 13, 7, 0, 0, 0, -524288, 1'b0, 2, 32'h44780000);
    do_word("fill last", 0, 1, 1, 1, 0, 0, 1'b0, 3, 32'h40108400);
    @(negedge clk);
    chk("full set", full, 1);
    chk("full count", count, 4);

    @(posedge clk); #1;
    req_op = 5'd0; req_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("held ready", req_ready, 0);
      chk("held wen", im_wen, 0);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    pulse_rewind();
    @(negedge clk);
    chk("rewind count", count, 0);
    chk("rewind full", full, 0);

    for (int i = 0; i < 3; i++)
      do_word("refill", 1, i, 0, 0, 0, 0, 1'b0, i, 32'h40000001 + (32'(i) << 20));
    do_word("rewind in write", 0, 5, 3, 7, 0, 0, 1'b1, 3, 32'h40519C00);
    @(negedge clk);
    chk("post-rewind count", count, 0);
    chk("post-rewind full", full, 0);
    do_word("after rewind", 4, 2, 2, 2, 0, 0, 1'b0, 0, 32'h40210803);

    @(posedge clk); #1;
    req_op = 5'd0; req_valid = 1'b1;
    for (int i = 0; i < 8 && !req_ready; i++) @(negedge clk);
    @(posedge clk); #1;
    req_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst in ENC wen", im_wen, 0);
    chk("rst in ENC count", count, 0);
    chk("rst in ENC err_code", err_code, 0);
    chk("rst in ENC ready", req_ready, 1);
    @(negedge clk);
    chk("rst in ENC no late write", im_wen, 0);

    for (int c = 0; c < 3000; c++) begin
      int op;
      @(posedge clk); #1;
      op = ($urandom_range(0, 99) < 88) ? int'($urandom_range(0, 18)) : int'($urandom_range(19, 31));
      req_valid = ($urandom_range(0, 99) < 60);
      req_op = 5'(op);
      req_rd = 5'($urandom_range(0, 31));
      req_ra = 5'($urandom_range(0, 31));
      req_rb = 5'($urandom_range(0, 31));
      req_sv = 2'($urandom_range(0, 3));
      req_imm = 32'(pick_imm(op));
      rewind = ($urandom_range(0, 99) < 5);
      rst = ($urandom_range(0, 999) < 4);
    end
    @(posedge clk); #1;
    req_valid = 1'b0; rewind = 1'b0; rst = 1'b0;
    repeat (4) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, %0d compared", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule
